// File: rtl/preprocess_pkg.sv
// Shared defaults and state encoding for the filter preprocessing blocks.
package preprocess_pkg;

    localparam int unsigned NUM_ENTRY_DEFAULT = 36;
    localparam int unsigned WW_DEFAULT        = 5;
    localparam int unsigned OW_DEFAULT        = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/first_one_finder.sv
// Lowest-set-bit priority encoder: index of the first 1 and a found flag.
module first_one_finder #(
    parameter int unsigned N  = 36,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/filter_compactor.sv
// Accepts a frame of filter entries and streams the kept ones out one per
// cycle in ascending index order.
module filter_compactor
    import preprocess_pkg::*;
#(
    parameter  int unsigned NUM_ENTRY = NUM_ENTRY_DEFAULT,
    parameter  int unsigned WW        = WW_DEFAULT,
    parameter  int unsigned OW        = OW_DEFAULT,
    localparam int unsigned IW        = $clog2(NUM_ENTRY),
    localparam int unsigned CW        = $clog2(NUM_ENTRY + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_ENTRY-1:0]    in_bit,
    input  logic [NUM_ENTRY*WW-1:0] in_weight,
    input  logic [NUM_ENTRY*OW-1:0] in_out,
    input  logic [NUM_ENTRY-1:0]    in_drop,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bit,
    output logic [WW-1:0]           out_weight,
    output logic [OW-1:0]           out_out,
    output logic [IW-1:0]           out_index,
    output logic                    out_last,
    output logic [CW-1:0]           kept_count,
    output logic                    frame_empty
);

    state_t                  state;
    logic [NUM_ENTRY-1:0]    mask;
    logic [NUM_ENTRY-1:0]    bit_q;
    logic [NUM_ENTRY*WW-1:0] weight_q;
    logic [NUM_ENTRY*OW-1:0] out_q;
    logic [IW-1:0]           idx;

    logic [NUM_ENTRY-1:0]    keep_vec;
    logic [NUM_ENTRY-1:0]    rest_mask;
    logic [NUM_ENTRY-1:0]    find_vec;
    logic [IW-1:0]           find_idx;
    logic                    find_ok;
    logic                    find_single;
    logic [CW-1:0]           kept_c;

    // One encoder serves both the first pick at acceptance and each advance.
    always_comb begin
        keep_vec    = ~in_drop;
        rest_mask   = mask & ~(NUM_ENTRY'(1) << idx);
        find_vec    = (state == IDLE) ? keep_vec : rest_mask;
        find_single = (find_vec & (find_vec - NUM_ENTRY'(1))) == '0;
        kept_c      = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            kept_c = kept_c + CW'(keep_vec[i]);
        end
    end

    first_one_finder #(
        .N  (NUM_ENTRY),
        .IW (IW)
    ) u_finder (
        .vec   (find_vec),
        .idx   (find_idx),
        .found (find_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            mask        <= '0;
            bit_q       <= '0;
            weight_q    <= '0;
            out_q       <= '0;
            kept_count  <= '0;
            frame_empty <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_bit     <= 1'b0;
            out_weight  <= '0;
            out_out     <= '0;
            out_index   <= '0;
        end else begin
            frame_empty <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bit_q      <= in_bit;
                        weight_q   <= in_weight;
                        out_q      <= in_out;
                        mask       <= keep_vec;
                        kept_count <= kept_c;
                        idx        <= find_idx;
                        if (find_ok) begin
                            state      <= SCAN;
                            in_ready   <= 1'b0;
                            out_valid  <= 1'b1;
                            out_last   <= find_single;
                            out_index  <= find_idx;
                            out_bit    <= in_bit[find_idx];
                            out_weight <= in_weight[find_idx*WW +: WW];
                            out_out    <= in_out[find_idx*OW +: OW];
                        end else begin
                            frame_empty <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        mask <= rest_mask;
                        if (out_last) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            idx        <= find_idx;
                            out_last   <= find_single;
                            out_index  <= find_idx;
                            out_bit    <= bit_q[find_idx];
                            out_weight <= weight_q[find_idx*WW +: WW];
                            out_out    <= out_q[find_idx*OW +: OW];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_compactor.sv
// Bench for filter_compactor: table-driven frames, random frames against a
// kept-index queue model, and hand sequences for stall, overlap and reset.
module tb_filter_compactor;

    localparam int unsigned N   = 36;
    localparam int unsigned WW  = 5;
    localparam int unsigned OW  = 6;
    localparam int unsigned IW  = 6;
    localparam int unsigned CW  = 6;
    localparam int unsigned N8  = 8;
    localparam int unsigned WW8 = 3;
    localparam int unsigned OW8 = 4;
    localparam int unsigned IW8 = 3;
    localparam int unsigned CW8 = 4;

    logic clk;
    logic reset;

    logic            in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0]    in_bit, in_drop;
    logic [N*WW-1:0] in_weight;
    logic [N*OW-1:0] in_out;
    logic            out_bit, out_last, frame_empty;
    logic [WW-1:0]   out_weight;
    logic [OW-1:0]   out_out;
    logic [IW-1:0]   out_index;
    logic [CW-1:0]   kept_count;

    logic              v8_valid, r8_ready, o8_valid, o8_ready;
    logic [N8-1:0]     v8_bit, v8_drop;
    logic [N8*WW8-1:0] v8_weight;
    logic [N8*OW8-1:0] v8_out;
    logic              o8_bit, o8_last, o8_empty;
    logic [WW8-1:0]    o8_weight;
    logic [OW8-1:0]    o8_out;
    logic [IW8-1:0]    o8_index;
    logic [CW8-1:0]    o8_kept;

    int total = 0;
    int bad   = 0;

    filter_compactor dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_bit(in_bit), .in_weight(in_weight), .in_out(in_out), .in_drop(in_drop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_weight(out_weight), .out_out(out_out),
        .out_index(out_index), .out_last(out_last),
        .kept_count(kept_count), .frame_empty(frame_empty)
    );

    filter_compactor #(.NUM_ENTRY(8), .WW(3), .OW(4)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(v8_valid), .in_ready(r8_ready),
        .in_bit(v8_bit), .in_weight(v8_weight), .in_out(v8_out), .in_drop(v8_drop),
        .out_valid(o8_valid), .out_ready(o8_ready),
        .out_bit(o8_bit), .out_weight(o8_weight), .out_out(o8_out),
        .out_index(o8_index), .out_last(o8_last),
        .kept_count(o8_kept), .frame_empty(o8_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic fill_rand(output logic [N-1:0] b, output logic [N*WW-1:0] w, output logic [N*OW-1:0] o);
        for (int i = 0; i < N; i++) begin
            b[i]          = 1'($urandom_range(0, 1));
            w[i*WW +: WW] = WW'($urandom);
            o[i*OW +: OW] = OW'($urandom);
        end
    endtask

    // Present one frame and drain it; expected order is the ascending list of
    // indices whose drop bit is clear. Entered and left at a falling edge.
    task automatic run_frame(input logic [N-1:0] b, input logic [N*WW-1:0] w,
                             input logic [N*OW-1:0] o, input logic [N-1:0] drop,
                             input int mode, output int first_idx, output int last_idx);
        int  exp_q[$];
        int  k;
        int  cyc;
        int  j;
        logic rdy;
        first_idx = -1;
        last_idx  = -1;
        for (int i = 0; i < N; i++) if (!drop[i]) exp_q.push_back(i);
        check("in_ready before frame", in_ready, 1);
        in_valid  = 1'b1;
        in_bit    = b;
        in_weight = w;
        in_out    = o;
        in_drop   = drop;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
        in_bit    = ~b;
        in_weight = ~w;
        in_out    = ~o;
        in_drop   = ~drop;
        check("kept_count", kept_count, exp_q.size());
        if (exp_q.size() == 0) begin
            check("frame_empty pulse", frame_empty, 1);
            check("out_valid empty", out_valid, 0);
            check("in_ready empty", in_ready, 1);
            @(negedge clk);
            check("frame_empty one cycle", frame_empty, 0);
            check("out_valid empty after", out_valid, 0);
            check("in_ready empty after", in_ready, 1);
            check("kept_count empty after", kept_count, 0);
            return;
        end
        check("frame_empty nonempty", frame_empty, 0);
        k   = 0;
        cyc = 0;
        while (k < exp_q.size() && cyc < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            j = exp_q[k];
            check($sformatf("out_valid[%0d]", k), out_valid, 1);
            check($sformatf("out_index[%0d]", k), out_index, j);
            check($sformatf("out_bit[%0d]", k), out_bit, b[j]);
            check($sformatf("out_weight[%0d]", k), out_weight, w[j*WW +: WW]);
            check($sformatf("out_out[%0d]", k), out_out, o[j*OW +: OW]);
            check($sformatf("out_last[%0d]", k), out_last, (k == exp_q.size() - 1));
            check($sformatf("in_ready scan[%0d]", k), in_ready, 0);
            check($sformatf("kept_hold[%0d]", k), kept_count, exp_q.size());
            if (rdy) begin
                if (k == 0) first_idx = j;
                last_idx = j;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("drain complete", k, exp_q.size());
        check("out_valid after last", out_valid, 0);
        check("in_ready after last", in_ready, 1);
        check("out_last after last", out_last, 0);
        check("kept_count after last", kept_count, exp_q.size());
    endtask

    typedef struct {
        logic [N-1:0] drop;
        int           mode;
        int           exp_kept;
        int           exp_first;
        int           exp_last;
    } vec_t;

    vec_t            tbl[6];
    logic [N-1:0]    b, drop;
    logic [N*WW-1:0] w;
    logic [N*OW-1:0] o;
    int              fi, li, dens;
    logic [N8-1:0]     b8, d8;
    logic [N8*WW8-1:0] w8;
    logic [N8*OW8-1:0] ov8;
    int                idx8[4];

    initial begin
        tbl[0] = '{36'h0, 0, 36, 0, 35};
        tbl[1] = '{36'hF_FFFF_FFFF, 0, 0, -1, -1};
        tbl[2] = '{~((36'h1 << 3) | (36'h1 << 17) | (36'h1 << 35)), 1, 3, 3, 35};
        tbl[3] = '{~36'h1, 0, 1, 0, 0};
        tbl[4] = '{~(36'h1 << 35), 1, 1, 35, 35};
        tbl[5] = '{36'h5_5555_5555, 2, 18, 1, 35};

        reset = 1'b1;
        in_valid = 1'b0; in_bit = '0; in_weight = '0; in_out = '0; in_drop = '0; out_ready = 1'b0;
        v8_valid = 1'b0; v8_bit = '0; v8_weight = '0; v8_out = '0; v8_drop = '0; o8_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset kept_count", kept_count, 0);
        check("reset frame_empty", frame_empty, 0);
        check("reset out_last", out_last, 0);
        check("reset in_ready8", r8_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Table of corner frames.
        for (int t = 0; t < 6; t++) begin
            fill_rand(b, w, o);
            run_frame(b, w, o, tbl[t].drop, tbl[t].mode, fi, li);
            check($sformatf("tbl%0d kept", t), kept_count, tbl[t].exp_kept);
            check($sformatf("tbl%0d first", t), fi, tbl[t].exp_first);
            check($sformatf("tbl%0d last", t), li, tbl[t].exp_last);
        end

        // A second frame offered during SCAN waits until the first completes.
        fill_rand(b, w, o);
        in_valid = 1'b1; in_bit = b; in_weight = w; in_out = o;
        in_drop = ~((36'h1 << 5) | (36'h1 << 9));
        out_ready = 1'b0;
        @(negedge clk);
        check("ovl first idx", out_index, 5);
        check("ovl in_ready busy", in_ready, 0);
        in_drop = ~(36'h1 << 20);
        @(negedge clk);
        check("ovl stall idx", out_index, 5);
        check("ovl stall in_ready", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("ovl second idx", out_index, 9);
        check("ovl second last", out_last, 1);
        check("ovl second in_ready", in_ready, 0);
        @(negedge clk);
        check("ovl idle in_ready", in_ready, 1);
        check("ovl idle out_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("ovl B valid", out_valid, 1);
        check("ovl B idx", out_index, 20);
        check("ovl B kept", kept_count, 1);
        check("ovl B last", out_last, 1);
        @(negedge clk);
        out_ready = 1'b0;
        check("ovl B done", out_valid, 0);
        check("ovl B in_ready", in_ready, 1);

        // Reset after two of five kept entries are emitted.
        fill_rand(b, w, o);
        in_valid = 1'b1; in_bit = b; in_weight = w; in_out = o;
        in_drop = ~((36'h1 << 2) | (36'h1 << 4) | (36'h1 << 10) | (36'h1 << 11) | (36'h1 << 30));
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst idx0", out_index, 2);
        @(negedge clk);
        check("rst idx1", out_index, 4);
        @(negedge clk);
        check("rst idx2 shown", out_index, 10);
        reset = 1'b1;
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 1);
        check("rst kept", kept_count, 0);
        out_ready = 1'b0;
        @(negedge clk);
        check("rst held out_valid", out_valid, 0);
        reset = 1'b0;
        @(negedge clk);
        fill_rand(b, w, o);
        run_frame(b, w, o, ~((36'h1 << 7) | (36'h1 << 8) | (36'h1 << 20)), 0, fi, li);
        check("post-rst first", fi, 7);
        check("post-rst last", li, 20);

        // Random frames with varying density.
        for (int r = 0; r < 25; r++) begin
            fill_rand(b, w, o);
            dens = $urandom_range(0, 100);
            for (int i = 0; i < N; i++) drop[i] = ($urandom_range(0, 99) < dens);
            if (r == 3) drop = '1;
            if (r == 4) drop = '0;
            run_frame(b, w, o, drop, 2, fi, li);
        end

        // Small configuration: keep even entries.
        b8  = 8'b0110_1001;
        w8  = 24'hFA_C953;
        ov8 = 32'h9E3D_71B5;
        d8  = 8'b1010_1010;
        idx8 = '{0, 2, 4, 6};
        v8_valid = 1'b1; v8_bit = b8; v8_weight = w8; v8_out = ov8; v8_drop = d8;
        o8_ready = 1'b1;
        @(negedge clk);
        v8_valid = 1'b0;
        check("n8 kept", o8_kept, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("n8 valid[%0d]", k), o8_valid, 1);
            check($sformatf("n8 index[%0d]", k), o8_index, idx8[k]);
            check($sformatf("n8 bit[%0d]", k), o8_bit, b8[idx8[k]]);
            check($sformatf("n8 weight[%0d]", k), o8_weight, w8[idx8[k]*WW8 +: WW8]);
            check($sformatf("n8 out[%0d]", k), o8_out, ov8[idx8[k]*OW8 +: OW8]);
            check($sformatf("n8 last[%0d]", k), o8_last, (k == 3));
            @(negedge clk);
        end
        o8_ready = 1'b0;
        check("n8 done valid", o8_valid, 0);
        check("n8 done ready", r8_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/filter_compactor.md
FILTER_COMPACTOR -- requirements
Module: filter_compactor

Interface
REQ-001 SHALL have parameter NUM_ENTRY, default 36, meaning filter entries per frame.
REQ-002 SHALL have parameter WW, default 5, meaning filter weight width per entry.
REQ-003 SHALL have parameter OW, default 6, meaning filter output width per entry.
REQ-004 SHALL derive IW = clog2(NUM_ENTRY) for the index width and CW = clog2(NUM_ENTRY+1) for the count width.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port in_valid, input, 1 bit: a frame is presented.
REQ-008 Port in_ready, output, 1 bit: a frame can be accepted.
REQ-009 Port in_bit, input, NUM_ENTRY bits: per-entry filter bit.
REQ-010 Port in_weight, input, NUM_ENTRY*WW bits: per-entry weight; entry j occupies bits [j*WW +: WW].
REQ-011 Port in_out, input, NUM_ENTRY*OW bits: per-entry output; entry j occupies bits [j*OW +: OW].
REQ-012 Port in_drop, input, NUM_ENTRY bits: 1 means the entry is discarded.
REQ-013 Port out_valid, output, 1 bit: a compacted entry is presented.
REQ-014 Port out_ready, input, 1 bit: the consumer accepts the presented entry.
REQ-015 Port out_bit, output, 1 bit; port out_weight, output, WW bits; port out_out, output, OW bits: data of the presented entry.
REQ-016 Port out_index, output, IW bits: original entry index of the presented entry.
REQ-017 Port out_last, output, 1 bit: the presented entry is the final kept entry of its frame.
REQ-018 Port kept_count, output, CW bits: number of kept entries in the current frame.
REQ-019 Port frame_empty, output, 1 bit: one-cycle pulse marking a frame with every entry dropped.

Function
REQ-020 SHALL implement two states: IDLE and SCAN.
REQ-021 SHALL drive in_ready = 1 only in IDLE; a frame handshake is in_valid & in_ready.
REQ-022 On a frame handshake, SHALL register in_bit, in_weight, in_out, a pending mask = ~in_drop, kept_count = popcount(~in_drop), and idx = the lowest index with in_drop = 0.
REQ-023 On a frame handshake with at least one kept entry, SHALL enter SCAN; out_valid SHALL be asserted in the next cycle (latency 1).
REQ-024 On a frame handshake with all entries dropped, SHALL stay in IDLE, assert frame_empty for exactly the next cycle, never assert out_valid for that frame, and set kept_count = 0.
REQ-025 In SCAN, SHALL hold out_valid = 1; out_bit, out_weight, out_out and out_index SHALL present entry idx.
REQ-026 In SCAN, out_last SHALL be 1 when entry idx is the only bit set in the pending mask.
REQ-027 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-028 On an output handshake that is not last, SHALL clear mask[idx] and set idx to the lowest remaining set mask bit, so one entry is emitted per cycle when out_ready stays high.
REQ-029 On an output handshake with out_last=1, SHALL return to IDLE; in_ready SHALL be 1 in the following cycle.
REQ-030 Kept entries SHALL be emitted in ascending original index order, each exactly once.
REQ-031 in_valid SHALL be ignored outside IDLE; the input data need not be held once accepted.
REQ-032 kept_count SHALL hold its value from frame acceptance until the next frame acceptance.

Reset
REQ-033 While reset=1, SHALL clear state to IDLE and clear idx, the mask, the data registers, kept_count and frame_empty; out_valid and out_last SHALL be 0 and in_ready SHALL be 1.
REQ-034 A reset asserted mid-frame SHALL discard the frame without emitting further entries.

Structure
REQ-035 The default values of NUM_ENTRY, WW and OW and the state encoding SHALL reside in the shared package preprocess_pkg.
REQ-036 SHALL instantiate one sub-module, first_one_finder: a parametrised lowest-set-bit priority encoder returning an index and a found flag, used both at frame acceptance and for next-idx selection.

Verification
REQ-037 Bench SHALL cover: in_drop=0, out_ready=1 always -> 36 consecutive out_valid cycles, out_index 0..35, out_last only on index 35, kept_count=36.
REQ-038 Bench SHALL cover: in_drop all ones -> frame_empty high for exactly 1 cycle, out_valid never asserted, kept_count=0, in_ready stays 1.
REQ-039 Bench SHALL cover: only entries 3, 17 and 35 kept, with out_ready toggling 1,0,1,0 -> out_index sequence 3,17,35 with data held during stalls, out_last on 35, kept_count=3.
REQ-040 Bench SHALL cover: a second frame presented during SCAN -> not accepted (in_ready=0); it is accepted in the cycle after the last handshake of the first frame.
REQ-041 Bench SHALL cover: reset pulsed after 2 of 5 kept entries are emitted -> out_valid=0 immediately, in_ready=1, and the next frame starts at its own lowest kept index.
REQ-042 Bench SHALL cover: parameters NUM_ENTRY=8, WW=3, OW=4 with in_drop=8'b1010_1010 -> out_index sequence 0,2,4,6 with matching weight and out slices.
